// File: rtl/hlsm_seq_pkg.sv
// Shared types for the HLSM job sequencer: FSM state encoding and the operand-set record.
package hlsm_seq_pkg;
  localparam int HLSM_W = 64;

  typedef enum logic [2:0] {
    DRAIN  = 3'd0,
    IDLE   = 3'd1,
    LAUNCH = 3'd2,
    RUN    = 3'd3,
    HOLD   = 3'd4
  } state_t;

  typedef struct packed {
    logic [HLSM_W-1:0] a;
    logic [HLSM_W-1:0] b;
    logic [HLSM_W-1:0] c;
    logic [HLSM_W-1:0] d;
  } job_t;

  // Jobs with a zero divisor are answered locally and never reach the HLSM.
  function automatic logic div0(input job_t j);
    return (j.b == '0) || (j.d == '0);
  endfunction
endpackage

// File: rtl/hlsm_seq_fifo.sv
// Synchronous job FIFO: DEPTH entries (power of 2), head visible combinationally on rdata.
module hlsm_seq_fifo import hlsm_seq_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic Clk,
  input  logic Rst,
  input  logic push,
  input  logic pop,
  input  job_t wdata,
  output job_t rdata,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  job_t          mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic          do_push, do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  // Push is refused when full even if a pop frees a slot in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rp];

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (do_push) mem[wp] <= wdata;
  end
endmodule

// File: rtl/hlsm_job_sequencer.sv
// Feeds buffered operand sets to the HLSM one at a time and returns z on a valid/ready stream.
// Optional Done watchdog: define HLSM_SEQ_TIMEOUT_EN.
module hlsm_job_sequencer import hlsm_seq_pkg::*; #(
  parameter int W         = HLSM_W,
  parameter int DEPTH     = 4,
  parameter int DRAIN_CYC = 12,
  parameter int TIMEOUT   = 64
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [W-1:0] in_c,
  input  logic [W-1:0] in_d,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_z,
  output logic         out_err,
  output logic         hlsm_start,
  input  logic         hlsm_done,
  output logic [W-1:0] hlsm_a,
  output logic [W-1:0] hlsm_b,
  output logic [W-1:0] hlsm_c,
  output logic [W-1:0] hlsm_d,
  output logic [W-1:0] hlsm_zero,
  input  logic [W-1:0] hlsm_z,
  output logic         busy,
  output logic         timeout
);
  localparam int CMAX = (DRAIN_CYC > TIMEOUT) ? DRAIN_CYC : TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          en_q, full, empty, push, pop;
  logic          ld_res, res_err, err_q;
  logic [W-1:0]  res_z, z_q;
  job_t          head, ops_q, in_job;

`ifdef HLSM_SEQ_TIMEOUT_EN
  logic tmo_q, redrain_q, tmo_set;
`endif

  assign in_job = '{a: in_a, b: in_b, c: in_c, d: in_d};
  // en_q keeps in_ready and busy low while reset is held and for the release cycle.
  assign in_ready = en_q & ~full;
  assign push     = in_valid & in_ready;
  assign busy     = en_q & ((state_q != IDLE) | ~empty);

  hlsm_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .Clk   (Clk),
    .Rst   (Rst),
    .push  (push),
    .pop   (pop),
    .wdata (in_job),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    ld_res  = 1'b0;
    res_z   = '0;
    res_err = 1'b0;
`ifdef HLSM_SEQ_TIMEOUT_EN
    tmo_set = 1'b0;
`endif
    case (state_q)
      DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(DRAIN_CYC - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (div0(head)) begin
            state_d = HOLD;
            ld_res  = 1'b1;
            res_err = 1'b1;
          end else begin
            state_d = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        state_d = RUN;
        cnt_d   = '0;
      end
      RUN: begin
        if (hlsm_done) begin
          state_d = HOLD;
          ld_res  = 1'b1;
          res_z   = hlsm_z;
        end
`ifdef HLSM_SEQ_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = HOLD;
          ld_res  = 1'b1;
          res_err = 1'b1;
          tmo_set = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      HOLD: begin
        if (out_ready) begin
          cnt_d   = '0;
`ifdef HLSM_SEQ_TIMEOUT_EN
          // A hung HLSM gets a full drain window before it is trusted again.
          state_d = redrain_q ? DRAIN : IDLE;
`else
          state_d = IDLE;
`endif
        end
      end
      default: state_d = DRAIN;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= DRAIN;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      ops_q   <= '0;
      z_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= 1'b1;
      if (pop) ops_q <= head;
      if (ld_res) begin
        z_q   <= res_z;
        err_q <= res_err;
      end
    end
  end

`ifdef HLSM_SEQ_TIMEOUT_EN
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      tmo_q     <= 1'b0;
      redrain_q <= 1'b0;
    end else begin
      if (tmo_set) tmo_q <= 1'b1;
      if (tmo_set) redrain_q <= 1'b1;
      else if (state_q == HOLD && out_ready) redrain_q <= 1'b0;
    end
  end
  assign timeout = tmo_q;
`else
  assign timeout = 1'b0;
`endif

  assign out_valid  = (state_q == HOLD);
  assign out_z      = z_q;
  assign out_err    = err_q;
  assign hlsm_start = (state_q == LAUNCH);
  assign hlsm_a     = ops_q.a;
  assign hlsm_b     = ops_q.b;
  assign hlsm_c     = ops_q.c;
  assign hlsm_d     = ops_q.d;
  assign hlsm_zero  = '0;
endmodule

// File: tb/tb_hlsm_job_sequencer.sv
// Bench for hlsm_job_sequencer: behavioural HLSM stand-in plus a queue-based result model.
module tb_hlsm_job_sequencer;
  localparam int W         = 64;
  localparam int DEPTH     = 4;
  localparam int DRAIN_CYC = 12;
  localparam int TIMEOUT   = 64;
  localparam int HLSM_LAT  = 5;

  logic         Clk = 1'b0;
  logic         Rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0, in_b = '0, in_c = '0, in_d = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_z;
  logic         out_err;
  logic         hlsm_start;
  logic         hlsm_done = 1'b0;
  logic [W-1:0] hlsm_a, hlsm_b, hlsm_c, hlsm_d, hlsm_zero;
  logic [W-1:0] hlsm_z = '0;
  logic         busy, timeout;

  always #5 Clk = ~Clk;

  hlsm_job_sequencer #(.W(W), .DEPTH(DEPTH), .DRAIN_CYC(DRAIN_CYC), .TIMEOUT(TIMEOUT)) dut (
    .Clk(Clk), .Rst(Rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .out_err(out_err),
    .hlsm_start(hlsm_start), .hlsm_done(hlsm_done),
    .hlsm_a(hlsm_a), .hlsm_b(hlsm_b), .hlsm_c(hlsm_c), .hlsm_d(hlsm_d),
    .hlsm_zero(hlsm_zero), .hlsm_z(hlsm_z),
    .busy(busy), .timeout(timeout)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // HLSM function: z = (a mod b) != 0 ? c/d : a/b
  function automatic logic [63:0] ref_z(input logic [63:0] a, b, c, d);
    return ((a % b) != 0) ? (c / d) : (a / b);
  endfunction

  // HLSM stand-in: no reset, fixed latency, z only meaningful while Done is high.
  logic        stub_busy = 1'b0;
  int          stub_cnt  = 0;
  logic [63:0] stub_z    = '0;
  bit          stub_dead = 1'b0;

  always @(posedge Clk) begin
    hlsm_done <= 1'b0;
    hlsm_z    <= 64'hBAD0_BAD0;
    if (!stub_busy) begin
      if (hlsm_start) begin
        stub_busy <= 1'b1;
        stub_cnt  <= HLSM_LAT;
        stub_z    <= ref_z(hlsm_a, hlsm_b, hlsm_c, hlsm_d);
      end
    end else if (stub_cnt == 1) begin
      stub_busy <= 1'b0;
      if (!stub_dead) begin
        hlsm_done <= 1'b1;
        hlsm_z    <= stub_z;
      end
    end else begin
      stub_cnt <= stub_cnt - 1;
    end
  end

  typedef struct {
    logic [63:0] a, b, c, d, z;
    logic        err;
  } exp_t;

  exp_t expq[$];
  int   cyc = 0, nstarts = 0, retired = 0;
  bit   launched = 1'b0, prev_start = 1'b0;

  // Compare process: the oldest unretired job is the one in flight or on the output.
  always @(negedge Clk) begin
    exp_t e;
    if (!Rst) begin
      expq.delete();
      launched   = 1'b0;
      prev_start = 1'b0;
      cyc        = 0;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_start", hlsm_start, 0);
      chk("rst_out_z", out_z, 0);
      chk("rst_busy", busy, 0);
    end else begin
      cyc++;
      chk("hlsm_zero", hlsm_zero, 0);
`ifndef HLSM_SEQ_TIMEOUT_EN
      chk("timeout_tied", timeout, 0);
`endif
      if (in_valid && in_ready) begin
        e.a = in_a; e.b = in_b; e.c = in_c; e.d = in_d;
        e.err = (in_b == 0) || (in_d == 0) || stub_dead;
        e.z   = e.err ? 64'd0 : ref_z(in_a, in_b, in_c, in_d);
        expq.push_back(e);
      end
      if (expq.size() == 0) begin
        chk("out_valid_no_job", out_valid, 0);
      end else if (out_valid) begin
        chk("out_z", out_z, expq[0].z);
        chk("out_err", out_err, expq[0].err);
        if (out_ready) begin
          void'(expq.pop_front());
          retired++;
        end
      end
      if (hlsm_start) begin
        nstarts++;
        chk("start_pulse", prev_start, 0);
        chk("start_after_drain", cyc > DRAIN_CYC, 1);
        chk("start_hlsm_idle", stub_busy, 0);
        if (expq.size() == 0) chk("start_no_job", hlsm_start, 0);
        else begin
          chk("start_job_ok", expq[0].err, 0);
          chk("start_a", hlsm_a, expq[0].a);
          chk("start_b", hlsm_b, expq[0].b);
          chk("start_c", hlsm_c, expq[0].c);
          chk("start_d", hlsm_d, expq[0].d);
          launched = 1'b1;
        end
      end
      if (hlsm_done && launched && expq.size() != 0) begin
        chk("done_a", hlsm_a, expq[0].a);
        chk("done_b", hlsm_b, expq[0].b);
        chk("done_c", hlsm_c, expq[0].c);
        chk("done_d", hlsm_d, expq[0].d);
        launched = 1'b0;
      end
      prev_start = hlsm_start;
    end
  end

  task automatic push(input logic [63:0] a, b, c, d, input int bound, output bit ok);
    in_a = a; in_b = b; in_c = c; in_d = d;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge Clk);
      if (in_ready) ok = 1'b1;
      @(posedge Clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic get_result(input string nm, input logic [63:0] ez, input logic ee, input int bound);
    bit got = 1'b0;
    for (int i = 0; i < bound && !got; i++) begin
      @(negedge Clk);
      if (out_valid) got = 1'b1;
    end
    chk({nm, "_arrived"}, got, 1);
    if (got) begin
      chk({nm, "_z"}, out_z, ez);
      chk({nm, "_err"}, out_err, ee);
    end
    @(posedge Clk); #1 out_ready = 1'b1;
    @(posedge Clk); #1 out_ready = 1'b0;
  endtask

  logic [63:0] fa [6] = '{17, 20, 9, 5, 30, 1};
  logic [63:0] fb [6] = '{ 5,  5, 4, 3,  6, 1};
  logic [63:0] fc [6] = '{100, 9, 50, 1, 1, 1};
  logic [63:0] fd [6] = '{ 7,  3, 5, 0,  1, 1};

  initial begin
    bit ok, got;
    int s0, r0, acc;
    #1;
    chk("rst0_in_ready", in_ready, 0);
    chk("rst0_out_valid", out_valid, 0);
    chk("rst0_timeout", timeout, 0);
    chk("rst0_out_err", out_err, 0);
    chk("rst0_hlsm_a", hlsm_a, 0);
    repeat (3) @(posedge Clk);
    #2 Rst = 1'b1;
    @(posedge Clk); #1;
    chk("rel_in_ready", in_ready, 1);
    chk("rel_busy", busy, 1);
    chk("rel_out_valid", out_valid, 0);

    // 17 mod 5 != 0 -> 100/7
    s0 = nstarts;
    push(17, 5, 100, 7, 50, ok);
    chk("t1_push", ok, 1);
    get_result("t1", 14, 0, 200);
    chk("t1_starts", nstarts - s0, 1);

    // 20 mod 5 == 0 -> 20/5
    push(20, 5, 9, 3, 50, ok);
    get_result("t2", 4, 0, 200);

    // zero divisor is screened
    s0 = nstarts;
    push(7, 0, 3, 4, 50, ok);
    get_result("t3", 0, 1, 200);
    chk("t3_no_start", nstarts - s0, 0);

    // fill: one job held in the result regs plus DEPTH queued
    acc = 0;
    r0  = retired;
    for (int j = 0; j < DEPTH + 2; j++) begin
      push(fa[j], fb[j], fc[j], fd[j], 20, ok);
      if (ok) acc++;
    end
    @(negedge Clk);
    chk("t4_accepted", acc, DEPTH + 1);
    chk("t4_in_ready_full", in_ready, 0);
    chk("t4_holding", out_valid, 1);
    @(posedge Clk); #1 out_ready = 1'b1;
    for (int i = 0; i < 400 && (retired - r0) < DEPTH + 1; i++) @(negedge Clk);
    @(posedge Clk); #1 out_ready = 1'b0;
    chk("t4_retired", retired - r0, DEPTH + 1);

    // reset while the HLSM is running
    push(17, 5, 100, 7, 50, ok);
    got = 1'b0;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge Clk);
      got = hlsm_start;
    end
    chk("t5_started", got, 1);
    @(posedge Clk); @(posedge Clk);
    #3 Rst = 1'b0;
    #1;
    chk("t5_in_ready", in_ready, 0);
    chk("t5_out_valid", out_valid, 0);
    chk("t5_start", hlsm_start, 0);
    chk("t5_out_z", out_z, 0);
    chk("t5_out_err", out_err, 0);
    chk("t5_hlsm_a", hlsm_a, 0);
    chk("t5_busy", busy, 0);
    chk("t5_timeout", timeout, 0);
    @(posedge Clk); @(posedge Clk);
    #2 Rst = 1'b1;
    @(posedge Clk); #1;
    push(20, 5, 9, 3, 50, ok);
    get_result("t5", 4, 0, 200);

`ifdef HLSM_SEQ_TIMEOUT_EN
    stub_dead = 1'b1;
    push(17, 5, 100, 7, 50, ok);
    get_result("t6", 0, 1, TIMEOUT + DRAIN_CYC + 50);
    chk("t6_timeout", timeout, 1);
    stub_dead = 1'b0;
    push(20, 5, 9, 3, 50, ok);
    get_result("t6_after", 4, 0, 200);
    chk("t6_sticky", timeout, 1);
`endif

    repeat (3) @(posedge Clk);
    #1;
    chk("end_busy", busy, 0);
    chk("end_in_ready", in_ready, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule
